// File: rtl/clk_switch_pkg.sv
// clk_switch_pkg: state encoding and default timing constants for clk_switch_ctrl
package clk_switch_pkg;
  typedef enum logic [2:0] {INIT, IDLE, DRAIN, ARM, ERR} state_t;
  localparam int unsigned DEF_TIMEOUT_CYC = 1024;
  localparam int unsigned DEF_DWELL_CYC = 16;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous status bit
// ports: clk, rst (sync, active-high, clears both flops), d (async in), q (synchronised out)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: select-request handshake, switch confirmation and timeout for a glitch-free clock mux
// ports: clk, rst (sync, active-high); req_valid/req_sel/req_ready request handshake;
//   select to mux; en0_stat/en1_stat async mux path status; busy, done (pulse), err (sticky),
//   err_clr, cur_sel (last confirmed source)
// optional macro CLK_SWITCH_DWELL_EN: enforce DWELL_CYC idle cycles after a switch or error recovery
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter bit          RESET_SEL   = 1'b0,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned CNT_W       = 11,
  parameter int unsigned DWELL_CYC   = DEF_DWELL_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic select,
  input  logic en0_stat,
  input  logic en1_stat,
  output logic busy,
  output logic done,
  output logic err,
  input  logic err_clr,
  output logic cur_sel
);
  state_t state, nxt;
  logic s0, s1, s_new, s_old, s_init, tmo, accept, dwell_ok;
  logic [CNT_W-1:0] cnt;
  sync_2ff u_sync0 (.clk(clk), .rst(rst), .d(en0_stat), .q(s0));
  sync_2ff u_sync1 (.clk(clk), .rst(rst), .d(en1_stat), .q(s1));
  // select already points at the new source while draining the old one
  assign s_new  = select ? s1 : s0;
  assign s_old  = select ? s0 : s1;
  assign s_init = RESET_SEL ? s1 : s0;
  assign tmo    = cnt == CNT_W'(TIMEOUT_CYC - 1);
  assign accept = req_valid & req_ready;
  assign err    = state == ERR;
`ifdef CLK_SWITCH_DWELL_EN
  localparam int DW_W = $clog2(DWELL_CYC + 2);
  logic [DW_W-1:0] dwell;
  always_ff @(posedge clk)
    if (rst) dwell <= '0;
    else if ((state == ARM || state == ERR) && nxt == IDLE) dwell <= DW_W'(DWELL_CYC);
    else if (dwell != '0) dwell <= dwell - 1'b1;
  assign dwell_ok = dwell == '0;
`else
  localparam int unsigned unused_dwell = DWELL_CYC;
  assign dwell_ok = 1'b1;
`endif
  // exit conditions take priority over the timeout in every waiting state
  always_comb begin
    nxt = state;
    req_ready = 1'b0;
    busy = 1'b0;
    case (state)
      INIT: begin
        busy = 1'b1;
        nxt = s_init ? IDLE : tmo ? ERR : INIT;
      end
      IDLE: begin
        req_ready = dwell_ok;
        nxt = (req_valid && dwell_ok && req_sel != cur_sel) ? DRAIN : IDLE;
      end
      DRAIN: begin
        busy = 1'b1;
        nxt = !s_old ? ARM : tmo ? ERR : DRAIN;
      end
      ARM: begin
        busy = 1'b1;
        nxt = s_new ? IDLE : tmo ? ERR : ARM;
      end
      ERR: nxt = err_clr ? IDLE : ERR;
      default: nxt = INIT;
    endcase
  end
  // the counter is zero in IDLE/ERR, so it starts from 0 on every DRAIN entry and runs on through ARM
  always_ff @(posedge clk)
    if (rst) begin
      state <= INIT;
      select <= RESET_SEL;
      cur_sel <= RESET_SEL;
      done <= 1'b0;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= busy ? cnt + 1'b1 : '0;
      done <= (accept && req_sel == cur_sel) || (state == ARM && s_new);
      if (accept && req_sel != cur_sel) select <= req_sel;
      if (state == ARM && s_new) cur_sel <= select;
      else if (state == ERR && err_clr) cur_sel <= s1 ? 1'b1 : s0 ? 1'b0 : cur_sel;
    end
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: scoreboard bench for clk_switch_ctrl with directed mux status stimulus
module tb_clk_switch_ctrl;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_sel = 1'b0;
  logic en0_stat = 1'b0, en1_stat = 1'b0, err_clr = 1'b0;
  logic req_ready, select, busy, done, err, cur_sel;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {int cyc; logic cur;} exp_t;
  exp_t q[$];
`ifdef CLK_SWITCH_DWELL_EN
  localparam int GAP = 16;
  localparam int RDY_AFTER_CLR = 0;
`else
  localparam int GAP = 1;
  localparam int RDY_AFTER_CLR = 1;
`endif

  clk_switch_ctrl #(.RESET_SEL(1'b0), .TIMEOUT_CYC(20), .CNT_W(11), .DWELL_CYC(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
    .select(select), .en0_stat(en0_stat), .en1_stat(en1_stat), .busy(busy), .done(done),
    .err(err), .err_clr(err_clr), .cur_sel(cur_sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // present a request at a negedge, hold until accepted, queue the expected done pulse
  task automatic req(input logic s, input int dly, input logic cur, output int acc);
    int n;
    exp_t e;
    req_valid = 1'b1;
    req_sel = s;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept_bound", int'(n < 200), 1);
    acc = cyc;
    if (dly > 0) begin
      e.cyc = acc + dly;
      e.cur = cur;
      q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // monitor: every done pulse must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_cur_sel", cur_sel, e.cur);
        chk("done_busy", busy, 0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc, acc2, d, n;
    tick(3);
    chk("rst_select", select, 0);
    chk("rst_cur_sel", cur_sel, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick(5);
    en0_stat = 1'b1;
    tick(1);
    chk("init_busy1", busy, 1);
    tick(1);
    chk("init_busy2", busy, 1);
    chk("init_ready2", req_ready, 0);
    tick(1);
    chk("init_exit_busy", busy, 0);
    chk("init_exit_ready", req_ready, 1);
    chk("init_exit_select", select, 0);
    // switch 0 -> 1 with slow mux status
    req(1'b1, 16, 1'b1, acc);
    chk("sw_select", select, 1);
    chk("sw_busy", busy, 1);
    chk("sw_ready", req_ready, 0);
    tick(6);
    en0_stat = 1'b0;
    tick(6);
    en1_stat = 1'b1;
    tick(5);
    chk("sw_cur_sel", cur_sel, 1);
    chk("sw_idle_busy", busy, 0);
    // same-source request
    req(1'b1, 1, 1'b1, acc);
    chk("same_select", select, 1);
    chk("same_busy", busy, 0);
    tick(2);
    // timeout: old source (clk1) never drains
    req(1'b0, 0, 1'b0, acc);
    chk("to_select", select, 0);
    chk("to_busy", busy, 1);
    tick(19);
    chk("to_pre_err", err, 0);
    chk("to_pre_busy", busy, 1);
    tick(1);
    chk("to_err", err, 1);
    chk("to_err_busy", busy, 0);
    chk("to_err_ready", req_ready, 0);
    chk("to_err_select", select, 0);
    tick(5);
    chk("to_err_sticky", err, 1);
    en1_stat = 1'b0;
    en0_stat = 1'b1;
    tick(3);
    chk("to_err_held", err, 1);
    chk("to_cur_held", cur_sel, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_cur_sel", cur_sel, 0);
    chk("clr_busy", busy, 0);
    chk("clr_ready", req_ready, RDY_AFTER_CLR);
    // reset in the middle of ARM
    req(1'b1, 0, 1'b1, acc);
    en0_stat = 1'b0;
    tick(4);
    chk("arm_busy", busy, 1);
    chk("arm_select", select, 1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_select", select, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_cur", cur_sel, 0);
    rst = 1'b0;
    en0_stat = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reinit_bound", int'(n < 50), 1);
    // back-to-back: switch, then a request issued one cycle after done
    req(1'b1, 5, 1'b1, acc);
    en0_stat = 1'b0;
    en1_stat = 1'b1;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_bound", int'(n < 50), 1);
    d = cyc;
    @(negedge clk);
    req(1'b1, 1, 1'b1, acc2);
    chk("b2b_gap", acc2 - d, GAP);
    tick(3);
    chk("pending_done", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
